// File: rtl/fir_n_tap_sequencer_if.sv
// Control bus between the FIR_N sequencer and its surroundings: sample/result handshakes,
// coefficient config port, and the RAM/MAC strobes that steer the shared datapath.
interface fir_n_tap_sequencer_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          cfg_req;
  logic          cfg_gnt;
  logic          cfg_we;
  logic          flush;
  logic          smp_we;
  logic          smp_zero;
  logic [AW-1:0] smp_waddr;
  logic [AW-1:0] smp_raddr;
  logic [AW-1:0] coef_raddr;
  logic          coef_we;
  logic          mac_en;
  logic          mac_clr;
  logic          acc_capture;
  logic          busy;

  // Environment side: feeds samples, consumes results, drives the config port.
  modport master (
    output in_valid, out_ready, cfg_req, cfg_we, flush,
    input  in_ready, out_valid, cfg_gnt, smp_we, smp_zero, smp_waddr, smp_raddr,
           coef_raddr, coef_we, mac_en, mac_clr, acc_capture, busy
  );

  modport slave (
    input  in_valid, out_ready, cfg_req, cfg_we, flush,
    output in_ready, out_valid, cfg_gnt, smp_we, smp_zero, smp_waddr, smp_raddr,
           coef_raddr, coef_we, mac_en, mac_clr, acc_capture, busy
  );
endinterface

// File: rtl/fir_n_tap_sequencer.sv
// Sequencer for a time-multiplexed N-tap FIR: one shared MAC stepped across a circular
// sample RAM and a coefficient RAM, with config-port arbitration and delay-line flush.
module fir_n_tap_sequencer #(
  parameter int N_TAPS  = 16,
  parameter int AW      = $clog2(N_TAPS),
  parameter int MAC_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  fir_n_tap_sequencer_if.slave bus
);

  localparam int            DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] LAST_TAP   = AW'(N_TAPS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {FLUSH, IDLE, MAC, DRAIN, CAPT, OUT} SeqState;

  SeqState       state_q, state_d;
  logic [AW-1:0] tapIdx_q, tapIdx_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] drainCnt_q, drainCnt_d;
  logic          started_q;

  logic [AW:0]   rdDiff;
  logic [AW-1:0] rdWrap;

  logic          inReady, outValid, cfgGnt, smpWe, smpZero;
  logic [AW-1:0] smpWaddr, smpRaddr, coefRaddr;
  logic          macEn, macClr, accCapture, busyFlag;

  // Newest sample sits at base; tap k reads base-k, folding a borrow back into 0..N_TAPS-1.
  assign rdDiff = {1'b0, base_q} - {1'b0, tapIdx_q};
  assign rdWrap = rdDiff[AW-1:0] + AW'(N_TAPS);

  // started_q holds every strobe low through reset and the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FLUSH;
      tapIdx_q   <= '0;
      wrPtr_q    <= '0;
      base_q     <= '0;
      drainCnt_q <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tapIdx_q   <= tapIdx_d;
      wrPtr_q    <= wrPtr_d;
      base_q     <= base_d;
      drainCnt_q <= drainCnt_d;
      started_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tapIdx_d   = tapIdx_q;
    wrPtr_d    = wrPtr_q;
    base_d     = base_q;
    drainCnt_d = drainCnt_q;
    inReady    = 1'b0;
    outValid   = 1'b0;
    cfgGnt     = 1'b0;
    smpWe      = 1'b0;
    smpZero    = 1'b0;
    smpWaddr   = '0;
    smpRaddr   = '0;
    coefRaddr  = '0;
    macEn      = 1'b0;
    macClr     = 1'b0;
    accCapture = 1'b0;
    busyFlag   = 1'b0;
    if (started_q) begin
      case (state_q)
        FLUSH: begin
          busyFlag = 1'b1;
          smpWe    = 1'b1;
          smpZero  = 1'b1;
          smpWaddr = tapIdx_q;
          if (tapIdx_q == LAST_TAP) begin
            tapIdx_d = '0;
            wrPtr_d  = '0;
            state_d  = IDLE;
          end else begin
            tapIdx_d = tapIdx_q + 1'b1;
          end
        end
        IDLE: begin
          if (bus.cfg_req) begin
            cfgGnt = 1'b1;
          end else if (bus.flush) begin
            tapIdx_d = '0;
            state_d  = FLUSH;
          end else begin
            inReady = 1'b1;
            if (bus.in_valid) begin
              smpWe    = 1'b1;
              smpWaddr = wrPtr_q;
              base_d   = wrPtr_q;
              wrPtr_d  = (wrPtr_q == LAST_TAP) ? '0 : wrPtr_q + 1'b1;
              tapIdx_d = '0;
              state_d  = MAC;
            end
          end
        end
        MAC: begin
          busyFlag  = 1'b1;
          macEn     = 1'b1;
          macClr    = (tapIdx_q == '0);
          coefRaddr = tapIdx_q;
          smpRaddr  = rdDiff[AW] ? rdWrap : rdDiff[AW-1:0];
          if (tapIdx_q == LAST_TAP) begin
            tapIdx_d   = '0;
            drainCnt_d = '0;
            state_d    = DRAIN;
          end else begin
            tapIdx_d = tapIdx_q + 1'b1;
          end
        end
        DRAIN: begin
          busyFlag = 1'b1;
          if (drainCnt_q == LAST_DRAIN) begin
            state_d = CAPT;
          end else begin
            drainCnt_d = drainCnt_q + 1'b1;
          end
        end
        CAPT: begin
          busyFlag   = 1'b1;
          accCapture = 1'b1;
          state_d    = OUT;
        end
        OUT: begin
          busyFlag = 1'b1;
          outValid = 1'b1;
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          tapIdx_d = '0;
          state_d  = FLUSH;
        end
      endcase
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid;
  assign bus.cfg_gnt     = cfgGnt;
  assign bus.coef_we     = bus.cfg_we & cfgGnt;
  assign bus.smp_we      = smpWe;
  assign bus.smp_zero    = smpZero;
  assign bus.smp_waddr   = smpWaddr;
  assign bus.smp_raddr   = smpRaddr;
  assign bus.coef_raddr  = coefRaddr;
  assign bus.mac_en      = macEn;
  assign bus.mac_clr     = macClr;
  assign bus.acc_capture = accCapture;
  assign bus.busy        = busyFlag;

endmodule

// File: tb/tb_fir_n_tap_sequencer.sv
// Bench for fir_n_tap_sequencer: a behavioural RAM/MAC datapath follows the DUT strobes,
// and a scoreboard compares its outputs against a shift-register FIR reference.
module tb_fir_n_tap_sequencer;

  localparam int N_TAPS  = 16;
  localparam int AW      = 4;
  localparam int MAC_LAT = 2;
  localparam int LATENCY = N_TAPS + MAC_LAT + 2;

  logic          clk;
  logic          rst;
  logic [15:0]   inData;
  logic [AW-1:0] cfgAddr;
  logic [15:0]   cfgData;
  logic [AW-1:0] lastWaddr;
  logic [15:0]   tbCoef [N_TAPS];
  int            vectorCount;
  int            missCount;
  int            cycleNum;

  fir_n_tap_sequencer_if #(.AW(AW)) bus ();

  fir_n_tap_sequencer #(
    .N_TAPS (N_TAPS),
    .AW     (AW),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleNum = 0;
  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
               tag, observed, expected, cycleNum);
    end
  endtask

  // Datapath stand-in: RAMs written on strobes, two-stage MAC pipeline, output register.
  logic [15:0] smpRam  [N_TAPS];
  logic [15:0] coefRam [N_TAPS];
  logic [31:0] prodP1, prodP2, acc, outReg;
  logic        enP1, enP2, clrP1, clrP2;

  always @(negedge clk) begin
    if (rst) begin
      enP1 <= 1'b0;
      enP2 <= 1'b0;
    end else begin
      enP1   <= bus.mac_en;
      clrP1  <= bus.mac_clr;
      prodP1 <= 32'(smpRam[bus.smp_raddr]) * 32'(coefRam[bus.coef_raddr]);
      enP2   <= enP1;
      clrP2  <= clrP1;
      prodP2 <= prodP1;
      if (enP2) acc <= clrP2 ? prodP2 : acc + prodP2;
      if (bus.acc_capture) outReg <= acc;
      if (bus.smp_we) smpRam[bus.smp_waddr] <= bus.smp_zero ? 16'd0 : inData;
      if (bus.coef_we) coefRam[cfgAddr] <= cfgData;
    end
  end

  // Scoreboard: reference FIR over a plain shift register of accepted samples.
  logic [31:0] expQ [$];
  int          latQ [$];
  logic [15:0] hist [N_TAPS];
  logic [31:0] expAcc;
  logic        outValidPrev;

  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      latQ.delete();
      for (int j = 0; j < N_TAPS; j++) hist[j] = 16'd0;
      outValidPrev = 1'b0;
    end else begin
      if (bus.flush && !bus.busy && !bus.cfg_req) begin
        for (int j = 0; j < N_TAPS; j++) hist[j] = 16'd0;
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int j = N_TAPS - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = inData;
        expAcc = 32'd0;
        for (int j = 0; j < N_TAPS; j++) expAcc = expAcc + 32'(tbCoef[j]) * 32'(hist[j]);
        expQ.push_back(expAcc);
        latQ.push_back(cycleNum);
      end
      if (bus.out_valid && !outValidPrev) begin
        if (latQ.size() == 0) checkOutput("spurious_out_valid", 32'd1, 32'd0);
        else checkOutput("latency", 32'(cycleNum - latQ.pop_front()), 32'(LATENCY));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) checkOutput("sb_empty", 32'd1, 32'd0);
        else checkOutput("result", outReg, expQ.pop_front());
      end
      outValidPrev = bus.out_valid;
    end
  end

  task automatic applyStimulus(input logic [15:0] sample);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    inData = sample;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        lastWaddr = bus.smp_waddr;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("accept_wait", 32'(done), 32'd1);
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    checkOutput("idle_wait", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlush(input string tag);
    for (int i = 0; i < N_TAPS; i++) begin
      @(posedge clk);
      if (i == 0) begin
        #1;
        bus.flush = 1'b0;
      end
      @(negedge clk);
      checkOutput({tag, "_smp_we"}, 32'(bus.smp_we), 32'd1);
      checkOutput({tag, "_smp_zero"}, 32'(bus.smp_zero), 32'd1);
      checkOutput({tag, "_waddr"}, 32'(bus.smp_waddr), 32'(i));
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic loadCoefs();
    bus.cfg_req = 1'b1;
    bus.cfg_we  = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      cfgAddr   = AW'(i);
      cfgData   = 16'(i + 1);
      tbCoef[i] = 16'(i + 1);
      @(negedge clk);
      checkOutput("load_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
      checkOutput("load_coef_we", 32'(bus.coef_we), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.cfg_req = 1'b0;
    bus.cfg_we  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", missCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    vectorCount   = 0;
    missCount     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cfg_req   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.flush     = 1'b0;
    inData        = 16'd0;
    cfgAddr       = '0;
    cfgData       = 16'd0;
    for (int i = 0; i < N_TAPS; i++) tbCoef[i] = 16'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_smp_we", 32'(bus.smp_we), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkFlush("por");

    loadCoefs();

    // Impulse response, the 17th sample also exercising the write/read pointer wrap.
    bus.out_ready = 1'b1;
    applyStimulus(16'd1);
    for (int i = 0; i < N_TAPS - 1; i++) applyStimulus(16'd0);
    applyStimulus(16'd0);
    checkOutput("wrap_waddr", 32'(lastWaddr), 32'd0);
    for (int k = 0; k < N_TAPS; k++) begin
      @(negedge clk);
      checkOutput("wrap_mac_en", 32'(bus.mac_en), 32'd1);
      checkOutput("wrap_raddr", 32'(bus.smp_raddr), 32'((N_TAPS - k) % N_TAPS));
      checkOutput("wrap_coef_raddr", 32'(bus.coef_raddr), 32'(k));
      checkOutput("wrap_mac_clr", 32'(bus.mac_clr), 32'(k == 0));
    end
    waitIdle();

    // Backpressure: result held while downstream stalls.
    bus.out_ready = 1'b0;
    applyStimulus(16'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput("hold_wait", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.cfg_req  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold_cfg_gnt", 32'(bus.cfg_gnt), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cfg_req   = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_busy", 32'(bus.busy), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Config request collides with a pending sample.
    bus.cfg_req  = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b1;
    inData       = 16'd7;
    repeat (3) begin
      @(negedge clk);
      checkOutput("arb_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
      checkOutput("arb_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("arb_coef_we_idle", 32'(bus.coef_we), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.cfg_we = 1'b1;
    cfgAddr    = '0;
    cfgData    = tbCoef[0];
    @(negedge clk);
    checkOutput("arb_coef_we", 32'(bus.coef_we), 32'd1);
    @(posedge clk);
    #1;
    bus.cfg_we  = 1'b0;
    bus.cfg_req = 1'b0;
    @(negedge clk);
    checkOutput("arb_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_req  = 1'b1;
    bus.cfg_we   = 1'b1;
    cfgAddr      = AW'(3);
    cfgData      = 16'd99;
    repeat (3) begin
      @(negedge clk);
      checkOutput("busy_cfg_gnt", 32'(bus.cfg_gnt), 32'd0);
      checkOutput("busy_coef_we", 32'(bus.coef_we), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.cfg_req = 1'b0;
    bus.cfg_we  = 1'b0;
    waitIdle();

    // Explicit flush clears history and rewinds the write pointer.
    bus.flush = 1'b1;
    checkFlush("flush");
    applyStimulus(16'd2);
    checkOutput("flush_wrptr", 32'(lastWaddr), 32'd0);
    waitIdle();

    // Reset in the middle of a MAC pass.
    applyStimulus(16'd3);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("pre_rst_mac_en", 32'(bus.mac_en), 32'd1);
    checkOutput("pre_rst_coef_raddr", 32'(bus.coef_raddr), 32'd7);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_mac_en", 32'(bus.mac_en), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_smp_we", 32'(bus.smp_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkFlush("rerun");
    applyStimulus(16'd9);
    checkOutput("rst_wrptr", 32'(lastWaddr), 32'd0);
    waitIdle();

    repeat (5) @(posedge clk);
    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
